// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART command-packet decoder and its consumers.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        S_SYNC   = 3'd0,
        S_OPCODE = 3'd1,
        S_ADDR   = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Opcodes understood by the network control logic downstream.
    localparam logic [7:0] OP_WRITE_WEIGHT = 8'h01;
    localparam logic [7:0] OP_READ         = 8'h02;
    localparam logic [7:0] OP_INJECT_SPIKE = 8'h03;

    function automatic int cmd_data_width(input int data_bytes);
        return 8 * data_bytes;
    endfunction

endpackage

// File: rtl/uart_pkt_timeout.sv
// Inter-byte watchdog: reloadable down-counter whose terminal count flags an idle link.
module uart_pkt_timeout #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // A load in the terminal cycle (a byte arriving) suppresses the expiry.
    assign tc = enable && !load && (count == '0);

endmodule

// File: rtl/uart_packet_decoder.sv
// Assembles UART bytes into sync/opcode/addr/data/checksum packets and holds each
// validated command in a single-entry valid/ready output register.
module uart_packet_decoder
    import uart_pkt_pkg::*;
#(
    parameter int         DATA_BYTES     = 2,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  rx_valid,
    input  logic [7:0]                            rx_data,
    input  logic                                  rx_break,
    output logic                                  cmd_valid,
    input  logic                                  cmd_ready,
    output logic [7:0]                            cmd_opcode,
    output logic [7:0]                            cmd_addr,
    output logic [cmd_data_width(DATA_BYTES)-1:0] cmd_data,
    output logic                                  err_checksum,
    output logic                                  err_timeout,
    output logic                                  err_overrun
);

    localparam int         CMD_W     = cmd_data_width(DATA_BYTES);
    localparam int         TO_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [2:0] LAST_BYTE = 3'(DATA_BYTES - 1);

    // Handshake: a command transfers on any cycle where cmd_valid and cmd_ready are both
    // high; while cmd_valid is high and cmd_ready low the command fields do not change.

    state_t           state;
    logic [7:0]       acc;
    logic [7:0]       opcode_sh;
    logic [7:0]       addr_sh;
    logic [CMD_W-1:0] data_sh;
    logic [2:0]       byte_cnt;
    logic             byte_in;
    logic             good;
    logic             timeout_tc;

    assign byte_in = rx_valid && !rx_break;
    assign good    = byte_in && (state == S_CHECK) && (rx_data == acc);

    uart_pkt_timeout #(.WIDTH(TO_W)) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .load       (rx_valid || (state == S_SYNC)),
        .enable     (state != S_SYNC),
        .load_value (TO_W'(TIMEOUT_CYCLES - 1)),
        .tc         (timeout_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_SYNC;
            acc          <= '0;
            opcode_sh    <= '0;
            addr_sh      <= '0;
            data_sh      <= '0;
            byte_cnt     <= '0;
            cmd_valid    <= 1'b0;
            cmd_opcode   <= '0;
            cmd_addr     <= '0;
            cmd_data     <= '0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;

            // A new good packet may replace the held command in the handshake cycle.
            if (good && (!cmd_valid || cmd_ready)) begin
                cmd_valid  <= 1'b1;
                cmd_opcode <= opcode_sh;
                cmd_addr   <= addr_sh;
                cmd_data   <= data_sh;
            end else begin
                if (good) begin
                    err_overrun <= 1'b1;
                end
                if (cmd_valid && cmd_ready) begin
                    cmd_valid <= 1'b0;
                end
            end

            if (rx_valid && rx_break) begin
                state <= S_SYNC;
            end else if (timeout_tc) begin
                state       <= S_SYNC;
                err_timeout <= 1'b1;
            end else if (rx_valid) begin
                case (state)
                    S_SYNC: begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= S_OPCODE;
                            acc   <= '0;
                        end
                    end
                    S_OPCODE: begin
                        opcode_sh <= rx_data;
                        acc       <= acc ^ rx_data;
                        state     <= S_ADDR;
                    end
                    S_ADDR: begin
                        addr_sh  <= rx_data;
                        acc      <= acc ^ rx_data;
                        byte_cnt <= '0;
                        state    <= S_DATA;
                    end
                    S_DATA: begin
                        data_sh <= (data_sh << 8) | CMD_W'(rx_data);
                        acc     <= acc ^ rx_data;
                        if (byte_cnt == LAST_BYTE) begin
                            state <= S_CHECK;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                    S_CHECK: begin
                        if (rx_data != acc) begin
                            err_checksum <= 1'b1;
                        end
                        state <= S_SYNC;
                    end
                    default: state <= S_SYNC;
                endcase
            end
        end
    end

endmodule
